// File: rtl/cam_frame_capture_pkg.sv
// Shared types and size helpers for the camera frame capture block.
// Frame geometry is derived here so parent and bench agree on it.
package cam_frame_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    CAPTURE,
    DONE
  } state_t;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int out_w(input int h, input int hd);
    return h / hd;
  endfunction

  function automatic int out_h(input int v, input int vd);
    return v / vd;
  endfunction

  function automatic int out_n(input int h, input int v,
                               input int hd, input int vd);
    return out_w(h, hd) * out_h(v, vd);
  endfunction

endpackage

// File: rtl/cam_frame_capture_byte_pair.sv
// Byte pairing: alternates high/low byte while href is high and
// flags the line end plus a dangling odd byte.
module cam_byte_pair (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  dat,
  input  logic        href,
  output logic        pixel_valid,
  output logic [15:0] pixel,
  output logic        line_end,
  output logic        odd_byte
);

  logic       phase;
  logic       href_prev;
  logic [7:0] hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= 1'b0;
      href_prev <= 1'b0;
      hi        <= '0;
    end else begin
      href_prev <= href;
      phase     <= en & href & ~phase;
      if (en && href && !phase) hi <= dat;
    end
  end

  assign pixel_valid = en & href & phase;
  assign pixel       = {hi, dat};
  assign line_end    = en & href_prev & ~href;
  assign odd_byte    = line_end & phase;

endmodule

// File: rtl/cam_frame_capture.sv
// Camera frame capture: RGB565 pairing, decimation and linear
// write stream into scratchpad RAM, armed by software.
module cam_frame_capture
  import cam_frame_capture_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_DECIM    = 16,
  parameter int V_DECIM    = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            cam_dat,
  input  logic                  cam_href,
  input  logic                  cam_vsync,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  line_err,
  output logic                  overflow
);

  localparam int OUT_N = out_n(H_ACTIVE, V_ACTIVE, H_DECIM, V_DECIM);
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam int KW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] HMASK = CW'((1 << log2(H_DECIM)) - 1);
  localparam logic [RW-1:0] VMASK = RW'((1 << log2(V_DECIM)) - 1);

  state_t state, state_next;

  logic          vsync_prev;
  logic          vs_rise;
  logic          vs_fall;
  logic          cap;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [KW-1:0] kept_cnt;
  logic          pix_valid;
  logic [15:0]   pixel;
  logic          line_end;
  logic          odd_byte;
  logic          keep;

  assign vs_rise = cam_vsync & ~vsync_prev;
  assign vs_fall = ~cam_vsync & vsync_prev;
  assign cap     = (state == CAPTURE);

  cam_byte_pair u_pair (
    .clk         (clk),
    .reset       (reset),
    .en          (cap),
    .dat         (cam_dat),
    .href        (cam_href),
    .pixel_valid (pix_valid),
    .pixel       (pixel),
    .line_end    (line_end),
    .odd_byte    (odd_byte)
  );

  // Masks on the low counter bits replace any divide/modulo.
  assign keep = pix_valid
              && (col_cnt < CW'(H_ACTIVE))
              && (row_cnt < RW'(V_ACTIVE))
              && ((col_cnt & HMASK) == '0)
              && ((row_cnt & VMASK) == '0);

  always_comb begin
    state_next = state;
    if (abort && state != IDLE) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_next = ARM;
        ARM:     if (vs_rise) state_next = SYNC;
        SYNC:    if (vs_fall) state_next = CAPTURE;
        CAPTURE: if (vs_rise) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      line_err   <= 1'b0;
      overflow   <= 1'b0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      kept_cnt   <= '0;
    end else begin
      vsync_prev <= cam_vsync;
      done       <= (state_next == DONE);
      busy       <= (state_next == ARM) || (state_next == SYNC)
                 || (state_next == CAPTURE);
      wr_en      <= 1'b0;
      if (state == IDLE && start) begin
        line_err <= 1'b0;
        overflow <= 1'b0;
        wr_addr  <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
        kept_cnt <= '0;
      end else if (cap) begin
        if (odd_byte) line_err <= 1'b1;
        if (line_end && col_cnt != '0) begin
          col_cnt <= '0;
          if (row_cnt < RW'(V_ACTIVE)) row_cnt <= row_cnt + 1'b1;
        end else if (pix_valid && col_cnt < CW'(H_ACTIVE)) begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (keep && !abort) begin
          if (kept_cnt < KW'(OUT_N)) begin
            wr_en    <= 1'b1;
            wr_data  <= pixel;
            wr_addr  <= kept_cnt[ADDR_WIDTH-1:0];
            kept_cnt <= kept_cnt + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: frame table plus scoreboard of writes,
// with hand sequences for late vsync, abort and mid-frame reset.
module tb_cam_frame_capture;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] cam_dat;
  logic       cam_href;
  logic       cam_vsync;

  logic        busy0, done0, wr_en0, line_err0, overflow0;
  logic [3:0]  wr_addr0;
  logic [15:0] wr_data0;
  logic        busy1, done1, wr_en1, line_err1, overflow1;
  logic [3:0]  wr_addr1;
  logic [15:0] wr_data1;

  cam_frame_capture #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_DECIM(2), .V_DECIM(2), .ADDR_WIDTH(4)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cam_dat(cam_dat), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .busy(busy0), .done(done0), .wr_en(wr_en0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .line_err(line_err0), .overflow(overflow0)
  );

  // Five rows fit only two kept rows of output, so row 4 overflows.
  cam_frame_capture #(
    .H_ACTIVE(8), .V_ACTIVE(5), .H_DECIM(2), .V_DECIM(2), .ADDR_WIDTH(4)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cam_dat(cam_dat), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .busy(busy1), .done(done1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .line_err(line_err1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int lines;
    int nbytes;
    bit junk;
    int wr0;
    bit lerr;
    bit ovf0;
    int wr1;
    bit ovf1;
  } vec_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   m_idx;
  int   n_wr0;
  int   n_wr1;
  int   n_done0;
  int   n_done1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int l, input int n, input bit push);
    int p;
    cam_href = 1'b1;
    for (int k = 0; k < n; k++) begin
      cam_dat = 8'(l * 16 + k);
      if (push && (k % 2 == 1)) begin
        p = k / 2;
        if (l < 4 && p < 8 && l % 2 == 0 && p % 2 == 0) begin
          if (m_idx < 8)
            sb.push_back('{addr: 4'(m_idx),
                           data: {8'(l * 16 + k - 1), 8'(l * 16 + k)}});
          m_idx++;
        end
      end
      step();
    end
    cam_href = 1'b0;
    cam_dat  = 8'h00;
    repeat (3) step();
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (2) step();
  endtask

  task automatic run_frame(input int lines, input int nbytes,
                           input bit junk);
    m_idx   = 0;
    n_done0 = 0;
    n_done1 = 0;
    if (junk) begin
      cam_vsync = 1'b1;
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    if (junk) begin
      send_line(0, 16, 1'b0);
      cam_vsync = 1'b0;
      repeat (2) step();
      send_line(1, 16, 1'b0);
    end
    vs_pulse();
    for (int l = 0; l < lines; l++) send_line(l, nbytes, 1'b1);
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (3) step();
  endtask

  vec_t vecs[5];

  initial begin
    int base;
    total     = 0;
    bad       = 0;
    m_idx     = 0;
    n_wr0     = 0;
    n_wr1     = 0;
    n_done0   = 0;
    n_done1   = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    cam_dat   = 8'h00;
    cam_href  = 1'b0;
    cam_vsync = 1'b0;

    vecs[0] = '{4, 16, 1'b0, 8, 1'b0, 1'b0, 8, 1'b0};
    vecs[1] = '{4, 16, 1'b1, 8, 1'b0, 1'b0, 8, 1'b0};
    vecs[2] = '{4, 15, 1'b0, 8, 1'b1, 1'b0, 8, 1'b0};
    vecs[3] = '{6, 16, 1'b0, 8, 1'b0, 1'b0, 8, 1'b1};
    vecs[4] = '{8, 16, 1'b0, 8, 1'b0, 1'b0, 8, 1'b1};

    fork
      forever begin
        @(negedge clk);
        if (wr_en0) begin
          n_wr0++;
          if (sb.size() == 0) begin
            check("unexpected_write", 32'(wr_addr0), 32'hffff);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr0), 32'(e.addr));
            check("wr_data", 32'(wr_data0), 32'(e.data));
          end
        end
        if (wr_en1) n_wr1++;
        if (done0) begin
          n_done0++;
          check("busy_with_done", 32'(busy0), 0);
        end
        if (done1) n_done1++;
      end
    join_none

    repeat (2) step();
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_wr_en", 32'(wr_en0), 0);
    check("rst_wr_addr", 32'(wr_addr0), 0);
    check("rst_wr_data", 32'(wr_data0), 0);
    check("rst_line_err", 32'(line_err0), 0);
    check("rst_overflow", 32'(overflow0), 0);
    reset = 1'b0;
    repeat (2) step();

    for (int v = 0; v < 5; v++) begin
      n_wr0 = 0;
      n_wr1 = 0;
      run_frame(vecs[v].lines, vecs[v].nbytes, vecs[v].junk);
      check($sformatf("v%0d_writes", v), 32'(n_wr0), 32'(vecs[v].wr0));
      check($sformatf("v%0d_sb_left", v), 32'(sb.size()), 0);
      check($sformatf("v%0d_done_cnt", v), 32'(n_done0), 1);
      check($sformatf("v%0d_busy", v), 32'(busy0), 0);
      check($sformatf("v%0d_line_err", v), 32'(line_err0),
            32'(vecs[v].lerr));
      check($sformatf("v%0d_overflow", v), 32'(overflow0),
            32'(vecs[v].ovf0));
      check($sformatf("v%0d_writes1", v), 32'(n_wr1), 32'(vecs[v].wr1));
      check($sformatf("v%0d_overflow1", v), 32'(overflow1),
            32'(vecs[v].ovf1));
      check($sformatf("v%0d_line_err1", v), 32'(line_err1),
            32'(vecs[v].lerr));
      check($sformatf("v%0d_addr1_sat", v), 32'(wr_addr1), 32'h7);
      check($sformatf("v%0d_data1_last", v), 32'(wr_data1), 32'h2c2d);
      check($sformatf("v%0d_done1_cnt", v), 32'(n_done1), 1);
      check($sformatf("v%0d_busy1", v), 32'(busy1), 0);
      sb.delete();
    end

    // Abort mid-line: pixel 2 completes in the abort cycle, never written.
    n_done0 = 0;
    n_wr0   = 0;
    start   = 1'b1;
    step();
    start = 1'b0;
    vs_pulse();
    cam_href = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cam_dat = 8'(k);
      if (k == 1) sb.push_back('{addr: 4'd0, data: 16'h0001});
      if (k == 5) abort = 1'b1;
      step();
    end
    abort    = 1'b0;
    cam_href = 1'b0;
    check("abort_wr_en", 32'(wr_en0), 0);
    check("abort_busy", 32'(busy0), 0);
    repeat (6) step();
    check("abort_no_done", 32'(n_done0), 0);
    check("abort_writes", 32'(n_wr0), 1);
    check("abort_sb_left", 32'(sb.size()), 0);
    n_wr0 = 0;
    run_frame(4, 16, 1'b0);
    check("post_abort_writes", 32'(n_wr0), 8);
    check("post_abort_sb_left", 32'(sb.size()), 0);
    sb.delete();

    // Reset mid-frame, asserted between clock edges.
    m_idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    vs_pulse();
    cam_href = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cam_dat = 8'(k);
      if (k == 1) sb.push_back('{addr: 4'd0, data: 16'h0001});
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy0), 0);
    check("mid_rst_wr_en", 32'(wr_en0), 0);
    check("mid_rst_wr_addr", 32'(wr_addr0), 0);
    check("mid_rst_wr_data", 32'(wr_data0), 0);
    check("mid_rst_line_err", 32'(line_err0), 0);
    check("mid_rst_overflow", 32'(overflow0), 0);
    cam_href = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
    step();
    base = n_wr0;
    vs_pulse();
    send_line(0, 16, 1'b0);
    check("no_start_writes", 32'(n_wr0 - base), 0);
    check("no_start_busy", 32'(busy0), 0);
    n_wr0 = 0;
    run_frame(4, 16, 1'b0);
    check("post_rst_writes", 32'(n_wr0), 8);
    check("post_rst_done", 32'(n_done0), 1);
    check("post_rst_sb_left", 32'(sb.size()), 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
